mode_counter: RTL

Parametrised successor to the basic 8-bit loadable counter. Adds up/down counting, a programmable prescaler, wrap/saturate/one-shot modes, a compare register with match pulse, and terminal-count and sticky-overflow flags. Used as the general timer/event-counter primitive in the project datapath; software-style control comes from a register block that drives the strobes below.

---
 rtl/mode_counter_if.sv | 30 +++
 rtl/mode_counter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mode_counter_if.sv
// Control/status bundle for mode_counter: strobes and configuration in, count and flags out.
interface mode_counter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 4
);
  logic             clr_i;
  logic             we_i;
  logic [WIDTH-1:0] dat_i;
  logic             en_i;
  logic             dir_i;
  logic [1:0]       mode_i;
  logic [PRE_W-1:0] pre_i;
  logic             cmp_we_i;
  logic [WIDTH-1:0] cmp_i;
  logic [WIDTH-1:0] dat_o;
  logic             tc_o;
  logic             cmp_o;
  logic             ovf_o;
  logic             run_o;

  modport master (
    output clr_i, we_i, dat_i, en_i, dir_i, mode_i, pre_i, cmp_we_i, cmp_i,
    input  dat_o, tc_o, cmp_o, ovf_o, run_o
  );

  modport slave (
    input  clr_i, we_i, dat_i, en_i, dir_i, mode_i, pre_i, cmp_we_i, cmp_i,
    output dat_o, tc_o, cmp_o, ovf_o, run_o
  );
endinterface

// File: rtl/mode_counter.sv
// Prescaled up/down timer/event counter with wrap, saturate and one-shot modes,
// compare-match pulse, terminal-count pulse and sticky overflow.
module mode_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mode_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ModeWrap    = 2'b00,
    ModeSat     = 2'b01,
    ModeOneShot = 2'b10,
    ModeWrapAlt = 2'b11
  } mode_e;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             tc_q, tc_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             run_q, run_d;

  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] nxt;
  mode_e            mode;

  assign tick    = bus.en_i && (pre_q == bus.pre_i);
  assign term    = {WIDTH{bus.dir_i}};
  assign at_term = (cnt_q == term);
  assign nxt     = bus.dir_i ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
  assign mode    = mode_e'(bus.mode_i);

  always_comb begin
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    match_d = 1'b0;
    ovf_d   = ovf_q;
    run_d   = run_q;
    cmp_d   = bus.cmp_we_i ? bus.cmp_i : cmp_q;

    if (bus.clr_i) begin
      cnt_d = '0;
      pre_d = '0;
      ovf_d = 1'b0;
      run_d = 1'b1;
    end else if (bus.we_i) begin
      cnt_d = bus.dat_i;
      pre_d = '0;
      run_d = 1'b1;
    end else if (bus.en_i) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        // Match uses the pre-update compare register so a same-cycle cmp_we_i cannot alias.
        case (mode)
          ModeSat: begin
            if (at_term) begin
              tc_d  = 1'b1;
              ovf_d = 1'b1;
            end else begin
              cnt_d   = nxt;
              match_d = (nxt == cmp_q);
            end
          end
          ModeOneShot: begin
            if (run_q) begin
              cnt_d   = nxt;
              match_d = (nxt == cmp_q);
              if (nxt == term) begin
                tc_d  = 1'b1;
                run_d = 1'b0;
              end
            end
          end
          default: begin
            cnt_d   = nxt;
            match_d = (nxt == cmp_q);
            if (at_term) begin
              tc_d  = 1'b1;
              ovf_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      pre_q   <= '0;
      cmp_q   <= '0;
      tc_q    <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      cmp_q   <= cmp_d;
      tc_q    <= tc_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      run_q   <= run_d;
    end
  end

  assign bus.dat_o = cnt_q;
  assign bus.tc_o  = tc_q;
  assign bus.cmp_o = match_q;
  assign bus.ovf_o = ovf_q;
  assign bus.run_o = run_q;

endmodule
